mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator-side load/store unit sitting between the CPU datapath and the word-only data memory.
- The data memory exposes a 32-bit combinational read, a single word write enable, a word-aligned address and no byte enables.
- This block accepts one byte, halfword or word load/store request at a time over a valid/ready handshake.
- It performs read-modify-write for sub-word stores, sign- or zero-extends sub-word loads, flags misaligned accesses, and returns a one-cycle response.

Parameters:
- TRACE_EN, 1, when 1 every memory write prints "@<pc>: *<word addr> <= <merged word>" (hex) in simulation; no synthesis effect.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_op  in  3  operation code (package constants)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half is used for SB/SH
- req_pc  in  32  PC of the issuing instruction, used for the trace
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result; 0 for stores and errors
- resp_err  out  1  misaligned access; valid with resp_valid
- mem_addr  out  32  word-aligned address to memory, {addr[31:2],2'b00}
- mem_we  out  1  memory write enable
- mem_wdata  out  32  word to write
- mem_rdata  in  32  combinational read data for mem_addr

Behaviour:
- States:
  - IDLE: req_ready=1.
  - RD: mem_addr driven; mem_rdata captured into word_buf at the end of the cycle.
  - WR: mem_we=1 with the merged word.
  - DONE: resp_valid=1.
- Acceptance: on a clk edge with req_valid && req_ready, latch op, addr, wdata and pc.
- Transitions from IDLE on acceptance:
  - misaligned -> DONE with err=1.
  - loads -> RD.
  - SW -> WR.
  - SH/SB -> RD.
- Other transitions: RD -> DONE for loads, RD -> WR for SH/SB, WR -> DONE, DONE -> IDLE unconditionally.
- Latency, with acceptance edge T:
  - LW/LH/LHU/LB/LBU/SW: resp_valid high in the cycle after edge T+1.
  - SH/SB: resp_valid high in the cycle after edge T+2.
  - Misaligned: resp_valid high in the cycle after edge T.
- Misalignment rule: LW/SW need addr[1:0]==0; LH/LHU/SH need addr[0]==0. Misaligned accesses never assert mem_we.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by addr[1:0]; the halfword is selected by addr[1].
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Store merge: SB replaces lane addr[1:0] of word_buf with wdata[7:0]; SH replaces half addr[1] with wdata[15:0]; SW writes wdata, and word_buf is unused.
- mem_we = (state==WR) && !reset. It is high for exactly one cycle per store and never otherwise.
- mem_addr and mem_wdata are registered and held stable through RD/WR.
- resp_rdata and resp_err are registered and valid only while resp_valid=1. They are 0 otherwise.
- No new request is accepted while busy; req_valid outside IDLE is ignored, not queued.
- Reset values: state=IDLE, req_ready=1 (after reset), resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_we=0, mem_wdata=0, word_buf=0.
- Reset mid-operation: the operation is dropped, no write is issued and no response is produced. If reset coincides with WR, mem_we is suppressed.
- Reset with req_valid=1: the request is not accepted.
- Trace: printed on the WR cycle edge when TRACE_EN=1, using the latched pc.

Decomposition:
- Package mem_access_pkg:
  - op constants: LW=3'd0, LH=3'd1, LHU=3'd2, LB=3'd3, LBU=3'd4, SW=3'd5, SH=3'd6, SB=3'd7.
  - helper is_store(op) = op>=SW.
  - state encoding constants.
- Sub-module lane_align: purely combinational. It provides load extract/extend and store merge from (op, addr[1:0], word, wdata). Top-level keeps the FSM and registers.

Test Plan:
- Memory word 0x10 = 0x8899AABB. Issue LB at 0x11 -> resp_rdata=0xFFFFFFAA two edges after accept. LBU at 0x11 -> 0x000000AA. LH at 0x12 -> 0xFFFF8899. LHU at 0x12 -> 0x00008899.
- SB 0x000000CC at 0x12 with word 0x8899AABB -> exactly one mem_we cycle, mem_wdata=0x88CCAABB, mem_addr=0x10, resp_valid three edges after accept.
- SW 0x12345678 at 0x20 -> one write of 0x12345678, no RD state, resp_valid two edges after accept, resp_err=0. Follow with LW at 0x20 -> 0x12345678.
- LW at 0x22 and SH at 0x13 -> resp_err=1, resp_valid one edge after accept, mem_we never asserted, memory unchanged.
- Back-to-back: req_valid held high with four requests -> req_ready low while busy, each accepted only in IDLE, responses returned in order, none lost or duplicated.
- Reset asserted during the WR cycle of SH -> mem_we=0, no resp_valid, state IDLE next cycle with req_ready=1 and all outputs 0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared opcodes, FSM encoding and access-classification helpers for the
// load/store unit.
package mem_access_pkg;

    localparam logic [2:0] LW  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LHU = 3'd2;
    localparam logic [2:0] LB  = 3'd3;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] SW  = 3'd5;
    localparam logic [2:0] SH  = 3'd6;
    localparam logic [2:0] SB  = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic is_store(input logic [2:0] op);
        return op >= SW;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        logic bad;
        case (op)
            LW, SW:      bad = (addr_lo != 2'b00);
            LH, LHU, SH: bad = addr_lo[0];
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane selection: extracts and extends sub-word loads and
// merges sub-word store data into a full memory word.
module lane_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_data = word;
        case (op)
            LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     load_data = {24'h0, byte_sel};
            LH:      load_data = {{16{half_sel[15]}}, half_sel};
            LHU:     load_data = {16'h0, half_sel};
            default: load_data = word;
        endcase
    end

    always_comb begin
        store_word = word;
        case (op)
            SW: store_word = wdata;
            SH: begin
                if (addr_lo[1]) store_word[31:16] = wdata[15:0];
                else            store_word[15:0]  = wdata[15:0];
            end
            SB: begin
                case (addr_lo)
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    2'd3:    store_word[31:24] = wdata[7:0];
                    default: store_word[7:0]   = wdata[7:0];
                endcase
            end
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit in front of a word-only data memory:
// read-modify-write for sub-word stores, extension for sub-word loads.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter bit TRACE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    logic [1:0]  state;
    logic [2:0]  op_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic [31:0] word_buf;
    logic [31:0] align_word;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic        accept;

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_DONE);
    assign mem_we     = (state == ST_WR) && !reset;
    assign accept     = req_valid && req_ready;

    // The aligner works on the word being captured in RD; elsewhere its result is unused.
    assign align_word = (state == ST_RD) ? mem_rdata : word_buf;

    lane_align u_lane_align (
        .op         (op_q),
        .addr_lo    (addr_lo_q),
        .word       (align_word),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_q       <= LW;
            addr_lo_q  <= 2'b00;
            wdata_q    <= '0;
            pc_q       <= '0;
            word_buf   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= req_op;
                        addr_lo_q <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        pc_q      <= req_pc;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        if (is_misaligned(req_op, req_addr[1:0])) begin
                            resp_err <= 1'b1;
                            state    <= ST_DONE;
                        end else if (req_op == SW) begin
                            mem_wdata <= req_wdata;
                            state     <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    word_buf <= mem_rdata;
                    if (is_store(op_q)) begin
                        mem_wdata <= store_word;
                        state     <= ST_WR;
                    end else begin
                        resp_rdata <= load_data;
                        state      <= ST_DONE;
                    end
                end
                ST_WR: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (TRACE_EN && mem_we)
            $display("@%h: *%h <= %h", pc_q, mem_addr, mem_wdata);
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_access_unit #(.TRACE_EN(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write applied mid-cycle on the falling edge.
    logic [31:0] mem [0:15];
    bit          mem_loaded = 1'b0;
    int          wr_count = 0;
    logic [31:0] last_wdata = '0;
    logic [31:0] last_waddr = '0;

    assign mem_rdata = mem[mem_addr[5:2]];

    always @(negedge clk) begin
        if (!mem_loaded) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
            mem[4]     <= 32'h8899AABB;
            mem_loaded <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[5:2]] <= mem_wdata;
            wr_count   <= wr_count + 1;
            last_wdata <= mem_wdata;
            last_waddr <= mem_addr;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          writes;
        logic [31:0] wword;
    } vec_t;

    vec_t vecs [22];

    // Drive one request at posedge+1, return latency (edges after accept) and response.
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output logic post_valid, output logic [31:0] post_rdata,
                          output logic post_err);
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_pc    = 32'h1000 + addr;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        @(posedge clk); #1;
        post_valid = resp_valid;
        post_rdata = resp_rdata;
        post_err   = resp_err;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } b2b_t;

    b2b_t b2b [4];

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        logic        pv;
        logic [31:0] prd;
        logic        pe;
        int          w0;
        int          idx;
        int          got;
        int          extra;
        int          viol;
        int          resp_seen;
        logic        rb;

        vecs[0]  = '{LB,  32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 1, 0, 32'h0};
        vecs[1]  = '{LBU, 32'h11, 32'h0,        32'h000000AA, 1'b0, 1, 0, 32'h0};
        vecs[2]  = '{LH,  32'h12, 32'h0,        32'hFFFF8899, 1'b0, 1, 0, 32'h0};
        vecs[3]  = '{LHU, 32'h12, 32'h0,        32'h00008899, 1'b0, 1, 0, 32'h0};
        vecs[4]  = '{LB,  32'h13, 32'h0,        32'hFFFFFF88, 1'b0, 1, 0, 32'h0};
        vecs[5]  = '{LH,  32'h10, 32'h0,        32'hFFFFAABB, 1'b0, 1, 0, 32'h0};
        vecs[6]  = '{LW,  32'h10, 32'h0,        32'h8899AABB, 1'b0, 1, 0, 32'h0};
        vecs[7]  = '{SB,  32'h12, 32'h000000CC, 32'h0,        1'b0, 2, 1, 32'h88CCAABB};
        vecs[8]  = '{LW,  32'h10, 32'h0,        32'h88CCAABB, 1'b0, 1, 0, 32'h0};
        vecs[9]  = '{SH,  32'h10, 32'hFFFF1234, 32'h0,        1'b0, 2, 1, 32'h88CC1234};
        vecs[10] = '{LW,  32'h10, 32'h0,        32'h88CC1234, 1'b0, 1, 0, 32'h0};
        vecs[11] = '{SW,  32'h20, 32'h12345678, 32'h0,        1'b0, 1, 1, 32'h12345678};
        vecs[12] = '{LW,  32'h20, 32'h0,        32'h12345678, 1'b0, 1, 0, 32'h0};
        vecs[13] = '{LW,  32'h22, 32'h0,        32'h0,        1'b1, 0, 0, 32'h0};
        vecs[14] = '{SH,  32'h13, 32'h0000ABCD, 32'h0,        1'b1, 0, 0, 32'h0};
        vecs[15] = '{LH,  32'h11, 32'h0,        32'h0,        1'b1, 0, 0, 32'h0};
        vecs[16] = '{SW,  32'h21, 32'hDEADBEEF, 32'h0,        1'b1, 0, 0, 32'h0};
        vecs[17] = '{LBU, 32'h13, 32'h0,        32'h00000088, 1'b0, 1, 0, 32'h0};
        vecs[18] = '{SB,  32'h23, 32'h112233EE, 32'h0,        1'b0, 2, 1, 32'hEE345678};
        vecs[19] = '{LW,  32'h20, 32'h0,        32'hEE345678, 1'b0, 1, 0, 32'h0};
        vecs[20] = '{LW,  32'h10, 32'h0,        32'h88CC1234, 1'b0, 1, 0, 32'h0};
        vecs[21] = '{LHU, 32'h12, 32'h0,        32'h000088CC, 1'b0, 1, 0, 32'h0};

        b2b[0] = '{LW, 32'h10, 32'h0,        32'h88CC1234, 1'b0};
        b2b[1] = '{SB, 32'h21, 32'h00000077, 32'h0,        1'b0};
        b2b[2] = '{LH, 32'h22, 32'h0,        32'hFFFFEE34, 1'b0};
        b2b[3] = '{LW, 32'h23, 32'h0,        32'h0,        1'b1};

        // Reset with a request pending: it must not be accepted
        reset     = 1'b1;
        req_valid = 1'b1;
        req_op    = SW;
        req_addr  = 32'h20;
        req_wdata = 32'hDEADDEAD;
        req_pc    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready", {31'h0, req_ready}, 32'h1);
        check("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        check("reset resp_err", {31'h0, resp_err}, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_we", {31'h0, mem_we}, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        reset     = 1'b0;
        req_valid = 1'b0;
        resp_seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (resp_valid) resp_seen++;
        end
        check("reset no response", resp_seen, 0);
        check("reset no write", wr_count, 0);

        for (int i = 0; i < 22; i++) begin
            w0 = wr_count;
            do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, lat, rd, er, pv, prd, pe);
            check($sformatf("v%0d latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d rdata", i), rd, vecs[i].rdata);
            check($sformatf("v%0d err", i), {31'h0, er}, {31'h0, vecs[i].err});
            check($sformatf("v%0d writes", i), wr_count - w0, vecs[i].writes);
            check($sformatf("v%0d pulse", i), {31'h0, pv}, 32'h0);
            check($sformatf("v%0d rdata cleared", i), prd | {31'h0, pe}, 32'h0);
            if (vecs[i].writes != 0) begin
                check($sformatf("v%0d wdata", i), last_wdata, vecs[i].wword);
                check($sformatf("v%0d waddr", i), last_waddr, {vecs[i].addr[31:2], 2'b00});
            end
        end

        // Back-to-back with req_valid held high
        w0    = wr_count;
        idx   = 0;
        got   = 0;
        extra = 0;
        viol  = 0;
        req_op    = b2b[0].op;
        req_addr  = b2b[0].addr;
        req_wdata = b2b[0].wdata;
        req_pc    = 32'h2000;
        req_valid = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            rb = req_ready;
            @(posedge clk); #1;
            if (rb && req_valid) idx++;
            if (resp_valid) begin
                if (got < 4) begin
                    check($sformatf("b2b%0d rdata", got), resp_rdata, b2b[got].rdata);
                    check($sformatf("b2b%0d err", got), {31'h0, resp_err}, {31'h0, b2b[got].err});
                end else begin
                    extra++;
                end
                got++;
            end
            if ((idx > got || resp_valid) == req_ready) viol++;
            if (idx < 4) begin
                req_op    = b2b[idx].op;
                req_addr  = b2b[idx].addr;
                req_wdata = b2b[idx].wdata;
                req_pc    = 32'h2000 + idx;
            end else begin
                req_valid = 1'b0;
            end
        end
        check("b2b accepted", idx, 4);
        check("b2b responses", got, 4);
        check("b2b duplicates", extra, 0);
        check("b2b ready violations", viol, 0);
        check("b2b writes", wr_count - w0, 1);
        check("b2b write data", last_wdata, 32'hEE347778);

        // Reset asserted during the WR cycle of an SH
        w0 = wr_count;
        req_op    = SH;
        req_addr  = 32'h10;
        req_wdata = 32'h0000BEEF;
        req_pc    = 32'h3000;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rst-wr mem_we before reset", {31'h0, mem_we}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst-wr mem_we suppressed", {31'h0, mem_we}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst-wr req_ready", {31'h0, req_ready}, 32'h1);
        check("rst-wr outputs zero",
              resp_rdata | mem_addr | mem_wdata | {29'h0, resp_valid, resp_err, mem_we}, 32'h0);
        resp_seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (resp_valid) resp_seen++;
        end
        check("rst-wr no response", resp_seen, 0);
        check("rst-wr no write", wr_count - w0, 0);
        do_req(LW, 32'h10, 32'h0, lat, rd, er, pv, prd, pe);
        check("rst-wr memory unchanged", rd, 32'h88CC1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
